wb_initiator: RTL and testbench

Wishbone classic-cycle bus master for the user project: converts single-word requests on a valid/ready command port into Wishbone B4 classic cycles toward the peripheral bus splitter. It returns the read data or error status on a valid/ready response port. It is the initiator counterpart of the slave fabric (AES, SHA256, PIC) and lets on-chip engines (DMA, self-test) reach those peripherals without the management SoC. Each transaction has a bounded wait: a timeout counter aborts cycles that a slave never acknowledges.

---
 rtl/wb_initiator.sv | 190 +++++++++++++++++++
 tb/tb_wb_initiator.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_initiator.sv
// wb_initiator: single-word Wishbone B4 classic-cycle bus master.
// A request taken on the cmd port becomes one Wishbone cycle. The outcome
// (read data, slave error or timeout) is returned on the rsp port. A cycle
// that is never acknowledged is aborted after TIMEOUT strobe cycles.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid keeps its payload stable until that edge.
// Ready never depends combinationally on valid, and no output depends
// combinationally on any input.
module wb_initiator #(
  parameter int          TIMEOUT  = 255,      // strobe cycles before abort; 0 = never
  parameter int          TO_W     = 8,        // timeout counter width, TIMEOUT < 2**TO_W
  parameter logic [15:0] TXN_INIT = 16'h0000  // reset value of the transaction counter
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // command port
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  // response port
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  // Wishbone master
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  // status / debug
  output logic [15:0] txn_count_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Last timeout-counter value that is still allowed to wait for the slave.
  localparam int              TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_LAST_I);
  localparam bit              TO_EN     = (TIMEOUT != 0);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_we;
  logic [3:0]      r_sel;
  logic [31:0]     r_adr;
  logic [31:0]     r_dat;
  logic [TO_W-1:0] r_to_cnt;
  logic [31:0]     r_rsp_dat;
  logic            r_rsp_err;
  logic            r_rsp_to;
  logic [15:0]     r_txn;

  logic            w_load;
  logic            w_done;
  logic            w_txn_inc;
  logic [31:0]     w_rsp_dat;
  logic            w_rsp_err;
  logic            w_rsp_to;

  // Next-state and response decode; err beats ack, ack beats timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    w_txn_inc   = 1'b0;
    w_rsp_dat   = '0;
    w_rsp_err   = 1'b0;
    w_rsp_to    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          w_load      = 1'b1;
          w_state_nxt = S_BUS;
        end
      end
      S_BUS: begin
        if (wbm_err_i) begin
          w_done    = 1'b1;
          w_rsp_err = 1'b1;
        end else if (wbm_ack_i) begin
          w_done    = 1'b1;
          w_rsp_dat = r_we ? 32'h0 : wbm_dat_i;
        end else if (TO_EN && (r_to_cnt == TO_LAST)) begin
          w_done    = 1'b1;
          w_rsp_err = 1'b1;
          w_rsp_to  = 1'b1;
        end
        if (w_done) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          w_state_nxt = S_IDLE;
          w_txn_inc   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any cycle or pending response.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus request registers: loaded on command accept, held afterwards.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_we  <= 1'b0;
      r_sel <= '0;
      r_adr <= '0;
      r_dat <= '0;
    end else if (w_load) begin
      r_we  <= cmd_we_i;
      r_sel <= cmd_sel_i;
      r_adr <= cmd_adr_i;
      r_dat <= cmd_dat_i;
    end
  end

  // Timeout counter: cleared on accept, counts every strobe cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_to_cnt <= '0;
    end else if (w_load) begin
      r_to_cnt <= '0;
    end else if (r_state == S_BUS) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Response registers: captured when the bus cycle ends, stable through RESP.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
      r_rsp_to  <= 1'b0;
    end else if (w_done) begin
      r_rsp_dat <= w_rsp_dat;
      r_rsp_err <= w_rsp_err;
      r_rsp_to  <= w_rsp_to;
    end
  end

  // Completed-transaction counter, bumped on every response handshake.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_txn <= TXN_INIT;
    end else if (w_txn_inc) begin
      r_txn <= r_txn + 16'd1;
    end
  end

  assign cmd_ready_o   = (r_state == S_IDLE);
  assign rsp_valid_o   = (r_state == S_RESP);
  assign wbm_cyc_o     = (r_state == S_BUS);
  assign wbm_stb_o     = (r_state == S_BUS);
  assign wbm_we_o      = r_we;
  assign wbm_sel_o     = r_sel;
  assign wbm_adr_o     = r_adr;
  assign wbm_dat_o     = r_dat;
  assign rsp_dat_o     = r_rsp_dat;
  assign rsp_err_o     = r_rsp_err;
  assign rsp_timeout_o = r_rsp_to;
  assign txn_count_o   = r_txn;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: a slave model driven per transaction, a response
// scoreboard fed at command issue and drained by an independent monitor,
// and a second instance whose counter starts at 0xFFFF for the wrap case.
module tb_wb_initiator;

  localparam int TIMEOUT   = 255;
  localparam int MODE_ACK  = 0;
  localparam int MODE_ERR  = 1;
  localparam int MODE_BOTH = 2;
  localparam int MODE_NONE = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main instance signals ----------------
  logic        cmd_valid = 1'b0;
  logic        cmd_we    = 1'b0;
  logic [31:0] cmd_adr   = '0;
  logic [31:0] cmd_dat   = '0;
  logic [3:0]  cmd_sel   = '0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic [31:0] sdat = '0;
  logic        sack = 1'b0;
  logic        serr = 1'b0;
  logic [15:0] txn;
  logic [1:0]  dbg;

  // ---------------- wrap instance signals ----------------
  logic        c2_valid = 1'b0;
  logic        c2_ready;
  logic        r2_valid;
  logic        r2_ready = 1'b0;
  logic [31:0] r2_dat;
  logic        r2_err, r2_to;
  logic        m2_cyc, m2_stb, m2_we;
  logic [3:0]  m2_sel;
  logic [31:0] m2_adr, m2_dat;
  logic        s2_ack = 1'b0;
  logic [15:0] txn2;
  logic [1:0]  dbg2;

  wb_initiator #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_dat_i(sdat), .wbm_ack_i(sack),
    .wbm_err_i(serr), .txn_count_o(txn), .dbg_state_o(dbg)
  );

  wb_initiator #(.TIMEOUT(TIMEOUT), .TO_W(8), .TXN_INIT(16'hFFFF)) dut_wrap (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(c2_valid), .cmd_ready_o(c2_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(r2_valid), .rsp_ready_i(r2_ready), .rsp_dat_o(r2_dat),
    .rsp_err_o(r2_err), .rsp_timeout_o(r2_to),
    .wbm_cyc_o(m2_cyc), .wbm_stb_o(m2_stb), .wbm_we_o(m2_we), .wbm_sel_o(m2_sel),
    .wbm_adr_o(m2_adr), .wbm_dat_o(m2_dat), .wbm_dat_i(sdat), .wbm_ack_i(s2_ack),
    .wbm_err_i(1'b0), .txn_count_o(txn2), .dbg_state_o(dbg2)
  );

  // ---------------- scoreboard ----------------
  int          total  = 0;
  int          passed = 0;
  logic [33:0] exp_q[$];          // {timeout, err, dat}
  logic [15:0] exp_txn = 16'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: the response a correct master must return for the slave
  // behaviour chosen by the bench.
  function automatic logic [33:0] expected_rsp(input logic t_we, input int mode,
                                               input int waits, input logic [31:0] rdata);
    if (mode == MODE_NONE || waits + 1 > TIMEOUT) return {2'b11, 32'h0};
    if (mode != MODE_ACK) return {2'b01, 32'h0};
    return {2'b00, (t_we ? 32'h0 : rdata)};
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [33:0] act;
    logic [33:0] prev;
    logic [33:0] e;
    bit          stalled;
    stalled = 1'b0;
    prev    = '0;
    forever begin
      @(negedge clk);
      #2;
      act = {rsp_timeout, rsp_err, rsp_dat};
      if (rsp_valid) begin
        if (stalled) check("rsp_stable", act, prev);
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rsp", act, e);
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          prev    = act;
        end
      end else begin
        stalled = 1'b0;
      end
    end
  end

  // ---------------- driver: one transaction with slave behaviour ----------------
  // Entered and left right after a falling edge.
  task automatic run_txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                         input logic [3:0] t_sel, input int mode, input int waits,
                         input logic [31:0] t_rdata, input int hold);
    int n;
    int budget;
    int exp_cyc;
    bit stable_ok;
    bit resp_now;
    logic [33:0] e;
    e = expected_rsp(t_we, mode, waits, t_rdata);
    exp_q.push_back(e);
    exp_cyc = e[33] ? TIMEOUT : waits + 1;

    budget = 0;
    while (!cmd_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_we    = t_we;
    cmd_adr   = t_adr;
    cmd_dat   = t_dat;
    cmd_sel   = t_sel;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_we    = ~t_we;
    cmd_adr   = $urandom;
    cmd_dat   = $urandom;
    cmd_sel   = 4'($urandom);

    n = 0;
    budget = 0;
    stable_ok = 1'b1;
    while (budget < TIMEOUT + 20) begin
      if (cyc) begin
        n++;
        if (!stb || we !== t_we || sel !== t_sel || adr !== t_adr || wdat !== t_dat)
          stable_ok = 1'b0;
        resp_now = (n == waits + 1);
        sack = resp_now && (mode == MODE_ACK || mode == MODE_BOTH);
        serr = resp_now && (mode == MODE_ERR || mode == MODE_BOTH);
        sdat = resp_now ? t_rdata : $urandom;
      end else if (n > 0) begin
        break;
      end
      @(negedge clk);
      budget++;
    end
    sack = 1'b0;
    serr = 1'b0;
    check("cyc_len", n, exp_cyc);
    check("bus_stable", stable_ok, 1);
    check("rsp_valid_after_cyc", rsp_valid, 1);
    check("req_hold", {we, sel, adr, wdat}, {t_we, t_sel, t_adr, t_dat});

    for (int i = 0; i < hold; i++) begin
      check("cmd_ready_in_resp", cmd_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_txn = exp_txn + 16'd1;
    check("txn_count", txn, exp_txn);
    check("rsp_valid_drop", rsp_valid, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : driver
    int mode;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cyc_stb", {cyc, stb}, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_txn", txn, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_bus_regs", {we, sel, adr, wdat}, 0);
    check("rst_rsp_regs", {rsp_timeout, rsp_err, rsp_dat}, 0);

    // directed cases
    run_txn(1'b1, 32'h3000_0010, 32'hDEADBEEF, 4'hF, MODE_ACK, 0, 32'h0, 0);
    run_txn(1'b0, 32'h3000_0020, 32'h0, 4'hF, MODE_ACK, 3, 32'h1234_5678, 5);
    run_txn(1'b0, 32'h3000_0030, 32'h0, 4'h3, MODE_BOTH, 1, 32'hA5A5_A5A5, 0);
    run_txn(1'b1, 32'h3000_0040, 32'h5555_AAAA, 4'hC, MODE_NONE, 0, 32'h0, 1);
    run_txn(1'b0, 32'h3000_0050, 32'h0, 4'hF, MODE_ACK, TIMEOUT - 1, 32'hCAFE_F00D, 0);

    // ack/err while idle must not start or end anything
    sack = 1'b1;
    serr = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ack_ignored", {cyc, rsp_valid, cmd_ready}, 3'b001);
    end
    sack = 1'b0;
    serr = 1'b0;

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      mode = ($urandom_range(0, 19) == 0) ? MODE_NONE : int'($urandom_range(0, 2));
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), mode,
              int'($urandom_range(0, 6)), $urandom, int'($urandom_range(0, 3)));
    end

    // reset pulse in the middle of a bus cycle
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h3000_0100;
    cmd_sel   = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pre_rst_in_bus", cyc, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_txn = 16'h0;
    check("bus_rst_cyc_stb", {cyc, stb}, 0);
    check("bus_rst_rsp_valid", rsp_valid, 0);
    check("bus_rst_txn", txn, 0);
    check("bus_rst_cmd_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    check("bus_rst_no_rsp", rsp_valid, 0);
    run_txn(1'b1, 32'h3000_0200, 32'h0BAD_CAFE, 4'h1, MODE_ACK, 2, 32'h0, 0);

    // counter wrap on the second instance
    check("wrap_start", txn2, 16'hFFFF);
    c2_valid = 1'b1;
    cmd_we   = 1'b0;
    cmd_adr  = 32'h3000_0300;
    cmd_sel  = 4'hF;
    @(negedge clk);
    c2_valid = 1'b0;
    check("wrap_cyc", m2_cyc, 1);
    s2_ack = 1'b1;
    sdat   = 32'h7777_1111;
    @(negedge clk);
    s2_ack = 1'b0;
    check("wrap_rsp", {r2_valid, r2_to, r2_err, r2_dat}, {1'b1, 2'b00, 32'h7777_1111});
    r2_ready = 1'b1;
    @(negedge clk);
    r2_ready = 1'b0;
    check("wrap_txn", txn2, 16'h0000);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #(500_000);
    $display("FAIL watchdog: run exceeded time limit, %0d/%0d passed so far", passed, total);
    $fatal(1);
  end

endmodule
